// File: rtl/dcache_nway_pkg.sv
// Shared types for the N-way write-back data cache: controller states,
// the data word type and a width helper for way/age fields.
package dcache_nway_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WB     = 3'd1,
    S_FILL   = 3'd2,
    S_FLUSH  = 3'd3,
    S_CNT0   = 3'd4,
    S_CNT1   = 3'd5,
    S_HALTED = 3'd6
  } state_e;

  localparam int unsigned WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  // A 1-way cache still needs a 1-bit way/age field to stay legal.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/dcache_nway_lru.sv
// True-LRU age tracker for one set: age 0 is most recent, WAYS-1 is the victim.
module lru_nway #(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned AGE_W = 1
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        touch_i,
  input  logic [AGE_W-1:0]            way_i,
  output logic [WAYS-1:0][AGE_W-1:0]  age_o,
  output logic [AGE_W-1:0]            lru_way_o
);

  logic [WAYS-1:0][AGE_W-1:0] age_q, age_d;

  // Touched way becomes MRU; only ways younger than it age by one.
  always_comb begin
    age_d = age_q;
    for (int w = 0; w < WAYS; w++) begin
      if (!touch_i) begin
        age_d[w] = age_q[w];
      end else if (AGE_W'(w) == way_i) begin
        age_d[w] = '0;
      end else if (age_q[w] < age_q[way_i]) begin
        age_d[w] = age_q[w] + AGE_W'(1);
      end else begin
        age_d[w] = age_q[w];
      end
    end
  end

  // Age register, reset to a distinct age per way.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int w = 0; w < WAYS; w++) age_q[w] <= AGE_W'(w);
    end else begin
      age_q <= age_d;
    end
  end

  // Oldest way lookup.
  always_comb begin
    lru_way_o = '0;
    for (int w = 0; w < WAYS; w++)
      lru_way_o = (age_q[w] == AGE_W'(WAYS-1)) ? AGE_W'(w) : lru_way_o;
  end

  assign age_o = age_q;

endmodule

// File: rtl/dcache_nway.sv
// Write-back, write-allocate N-way set-associative data cache with true-LRU
// replacement, halt-time flush and hit/miss counter dump.
module dcache_nway
  import dcache_nway_pkg::*;
#(
  parameter int unsigned WAYS     = 2,
  parameter int unsigned SETS     = 8,
  parameter int unsigned WORDS    = 2,
  parameter logic [31:0] CNT_ADDR = 32'h0000_3100,
  parameter logic [31:0] BAD      = 32'hBAD1_BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  input  logic        dwait,
  input  logic [31:0] dload,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore
);

  localparam int unsigned WAY_W = idx_w(WAYS);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned TAG_W = 32 - IDX_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS-1);
  localparam logic [WAY_W-1:0] LAST_WAY  = WAY_W'(WAYS-1);
  localparam logic [IDX_W-1:0] LAST_SET  = IDX_W'(SETS-1);

  typedef struct packed {
    logic                    valid;
    logic                    dirty;
    logic [TAG_W-1:0]        tag;
    logic [WORDS-1:0][31:0]  data;
  } line_t;

  line_t line_q [SETS][WAYS];
  state_e state_q, state_d;
  logic [OFF_W-1:0] wcnt_q, wcnt_d;
  logic [WAY_W-1:0] victim_q, fway_q;
  logic [TAG_W-1:0] ltag_q;
  logic [IDX_W-1:0] lidx_q, fset_q;
  word_t hitcnt_q, misscnt_q;
  logic replay_q, halt_q;

  logic [TAG_W-1:0] req_tag_s;
  logic [IDX_W-1:0] req_idx_s;
  logic [OFF_W-1:0] req_off_s;
  logic req_s, hit_s, inv_s, match_s;
  logic [WAY_W-1:0] hit_way_s, inv_way_s, victim_s, touch_way_s;
  logic [SETS-1:0] touch_s;
  logic [WAYS-1:0][WAY_W-1:0] age_s [SETS];
  logic [WAY_W-1:0] lru_way_s [SETS];
  line_t vic_line_s, wb_line_s, fl_line_s;
  logic hit_cnt_s, miss_s, wr_hit_s, fill_we_s, fill_last_s, inval_s;

  assign {req_tag_s, req_idx_s, req_off_s} = dmemaddr[31:2];
  assign req_s      = dmemREN | dmemWEN;
  assign vic_line_s = line_q[req_idx_s][victim_s];
  assign wb_line_s  = line_q[lidx_q][victim_q];
  assign fl_line_s  = line_q[fset_q][fway_q];

  for (genvar s = 0; s < SETS; s++) begin : g_lru
    lru_nway #(.WAYS(WAYS), .AGE_W(WAY_W)) u_lru (
      .CLK(CLK), .nRST(nRST), .touch_i(touch_s[s]), .way_i(touch_way_s),
      .age_o(age_s[s]), .lru_way_o(lru_way_s[s])
    );
  end

  // Tag compare and victim choice; descending scan leaves the lowest invalid way.
  always_comb begin
    hit_s = 1'b0; hit_way_s = '0; inv_s = 1'b0; inv_way_s = '0; match_s = 1'b0;
    for (int w = WAYS-1; w >= 0; w--) begin
      match_s   = line_q[req_idx_s][w].valid && (line_q[req_idx_s][w].tag == req_tag_s);
      hit_s     = hit_s | match_s;
      hit_way_s = match_s ? WAY_W'(w) : hit_way_s;
      inv_s     = inv_s | !line_q[req_idx_s][w].valid;
      inv_way_s = !line_q[req_idx_s][w].valid ? WAY_W'(w) : inv_way_s;
    end
    victim_s = inv_s ? inv_way_s : lru_way_s[req_idx_s];
  end

  // Controller next state, memory-side outputs and datapath strobes.
  always_comb begin
    state_d = state_q; wcnt_d = wcnt_q;
    dhit = 1'b0; dmemload = BAD; flushed = 1'b0;
    dREN = 1'b0; dWEN = 1'b0; daddr = 32'h0; dstore = 32'h0;
    touch_s = '0; touch_way_s = '0;
    hit_cnt_s = 1'b0; miss_s = 1'b0; wr_hit_s = 1'b0;
    fill_we_s = 1'b0; fill_last_s = 1'b0; inval_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (halt || halt_q) begin
          state_d = S_FLUSH;
        end else if (req_s && hit_s) begin
          dhit = 1'b1;
          touch_s[req_idx_s] = 1'b1;
          touch_way_s = hit_way_s;
          hit_cnt_s = !replay_q;
          wr_hit_s = dmemWEN;
          dmemload = dmemWEN ? BAD : line_q[req_idx_s][hit_way_s].data[req_off_s];
        end else if (req_s) begin
          miss_s = 1'b1;
          wcnt_d = '0;
          state_d = (vic_line_s.valid && vic_line_s.dirty) ? S_WB : S_FILL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        dWEN = 1'b1;
        daddr = {wb_line_s.tag, lidx_q, wcnt_q, 2'b00};
        dstore = wb_line_s.data[wcnt_q];
        if (!dwait && wcnt_q == LAST_WORD) begin
          wcnt_d = '0; state_d = S_FILL;
        end else if (!dwait) begin
          wcnt_d = wcnt_q + OFF_W'(1);
        end else begin
          wcnt_d = wcnt_q;
        end
      end
      S_FILL: begin
        dREN = 1'b1;
        daddr = {ltag_q, lidx_q, wcnt_q, 2'b00};
        fill_we_s = !dwait;
        if (!dwait && wcnt_q == LAST_WORD) begin
          wcnt_d = '0; fill_last_s = 1'b1; state_d = S_IDLE;
          touch_s[lidx_q] = 1'b1;
          touch_way_s = victim_q;
        end else if (!dwait) begin
          wcnt_d = wcnt_q + OFF_W'(1);
        end else begin
          wcnt_d = wcnt_q;
        end
      end
      S_FLUSH: begin
        if (fl_line_s.valid && fl_line_s.dirty) begin
          dWEN = 1'b1;
          daddr = {fl_line_s.tag, fset_q, wcnt_q, 2'b00};
          dstore = fl_line_s.data[wcnt_q];
          if (!dwait && wcnt_q == LAST_WORD) begin
            wcnt_d = '0; inval_s = 1'b1;
          end else if (!dwait) begin
            wcnt_d = wcnt_q + OFF_W'(1);
          end else begin
            wcnt_d = wcnt_q;
          end
        end else begin
          inval_s = 1'b1;
        end
        state_d = (inval_s && fset_q == LAST_SET && fway_q == LAST_WAY) ? S_CNT0 : S_FLUSH;
      end
      S_CNT0: begin
        dWEN = 1'b1; daddr = CNT_ADDR; dstore = hitcnt_q;
        state_d = dwait ? S_CNT0 : S_CNT1;
      end
      S_CNT1: begin
        dWEN = 1'b1; daddr = CNT_ADDR + 32'd4; dstore = misscnt_q;
        state_d = dwait ? S_CNT1 : S_HALTED;
      end
      S_HALTED: flushed = 1'b1;
      default:  state_d = S_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Line storage, miss latches, flush walk pointers and counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) line_q[s][w] <= '0;
      victim_q <= '0; ltag_q <= '0; lidx_q <= '0; fset_q <= '0; fway_q <= '0;
      hitcnt_q <= 32'd0; misscnt_q <= 32'd0; replay_q <= 1'b0; halt_q <= 1'b0;
    end else begin
      halt_q <= halt_q | halt;
      if (wr_hit_s) begin
        line_q[req_idx_s][hit_way_s].data[req_off_s] <= dmemstore;
        line_q[req_idx_s][hit_way_s].dirty <= 1'b1;
      end
      if (fill_we_s) line_q[lidx_q][victim_q].data[wcnt_q] <= dload;
      if (fill_last_s) begin
        line_q[lidx_q][victim_q].valid <= 1'b1;
        line_q[lidx_q][victim_q].dirty <= 1'b0;
        line_q[lidx_q][victim_q].tag   <= ltag_q;
      end
      if (inval_s) begin
        line_q[fset_q][fway_q].valid <= 1'b0;
        line_q[fset_q][fway_q].dirty <= 1'b0;
        fway_q <= (fway_q == LAST_WAY) ? '0 : fway_q + WAY_W'(1);
        fset_q <= (fway_q == LAST_WAY) ? fset_q + IDX_W'(1) : fset_q;
      end
      if (miss_s) begin
        victim_q  <= victim_s;
        ltag_q    <= req_tag_s;
        lidx_q    <= req_idx_s;
        misscnt_q <= misscnt_q + 32'd1;
        replay_q  <= 1'b1;
      end else if (dhit) begin
        replay_q  <= 1'b0;
      end
      if (hit_cnt_s) hitcnt_q <= hitcnt_q + 32'd1;
    end
  end

endmodule
